// File: rtl/key_event_pkg.sv
// Shared constants for the key event block: FSM state codes, default timing and a
// constant-evaluable ceil(log2) used to size counters.
package key_event_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int DEF_TICK_DIV  = 50000;
    localparam int DEF_LONG_MS   = 1000;
    localparam int DEF_REPEAT_MS = 200;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/key_event_fsm.sv
// One key's classifier: turns a synchronised level into short / long / repeat pulses
// plus a long-hold level, timed by the shared millisecond tick.
module key_event_fsm
    import key_event_pkg::*;
#(
    parameter int LONG_MS   = DEF_LONG_MS,
    parameter int REPEAT_MS = DEF_REPEAT_MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic level,
    output logic key_short,
    output logic key_long,
    output logic key_rep,
    output logic key_held
);

    localparam int CNT_MAX_MS = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int CNT_W      = clog2(CNT_MAX_MS + 1);

    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);

    logic             lvl_q, lvl_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic             held_q, held_d;

    // The registered level is the edge-detect stage: IDLE is only ever entered with the
    // level low (or from reset), so seeing it high there is a rising edge.
    // An event fires on the tick that makes the counter reach its target.
    always_comb begin
        lvl_d   = level;
        state_d = state_q;
        cnt_d   = (tick && (cnt_q != CNT_SAT)) ? cnt_q + CNT_W'(1) : cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (lvl_q) begin
                    state_d = ST_PRESS;
                end
            end
            ST_PRESS: begin
                if (!lvl_q) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (tick && (cnt_q == LONG_LAST)) begin
                    long_d  = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (!lvl_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (tick && (cnt_q == REP_LAST)) begin
                    rep_d = 1'b1;
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q   <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            lvl_q   <= lvl_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= held_d;
        end
    end

    assign key_short = short_q;
    assign key_long  = long_q;
    assign key_rep   = rep_q;
    assign key_held  = held_q;

endmodule

// File: rtl/key_event.sv
// Key event top: shared millisecond prescaler, per-key 2-flop synchronisers and one
// classifier per key.
module key_event
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS  = 2,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int LONG_MS   = DEF_LONG_MS,
    parameter int REPEAT_MS = DEF_REPEAT_MS
) (
    input  logic                Sys_CLK,
    input  logic                Sys_RST_N,
    input  logic [NUM_KEYS-1:0] Key_In,
    output logic [NUM_KEYS-1:0] Key_Short,
    output logic [NUM_KEYS-1:0] Key_Long,
    output logic [NUM_KEYS-1:0] Key_Rep,
    output logic [NUM_KEYS-1:0] Key_Held
);

    localparam int                 PRESC_W   = clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                tick;
    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        sync1_d = Key_In;
        sync2_d = sync1_q;
    end

    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
        if (!Sys_RST_N) begin
            presc_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            presc_q <= presc_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_event_fsm #(
            .LONG_MS   (LONG_MS),
            .REPEAT_MS (REPEAT_MS)
        ) u_fsm (
            .clk       (Sys_CLK),
            .rst_n     (Sys_RST_N),
            .tick      (tick),
            .level     (sync2_q[i]),
            .key_short (Key_Short[i]),
            .key_long  (Key_Long[i]),
            .key_rep   (Key_Rep[i]),
            .key_held  (Key_Held[i])
        );
    end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with TICK_DIV=4, LONG_MS=5, REPEAT_MS=3; each scenario
// starts from reset so the prescaler phase, and thus every event cycle, is known.
module tb_key_event;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [1:0] key_in;
    logic [1:0] key_short;
    logic [1:0] key_long;
    logic [1:0] key_rep;
    logic [1:0] key_held;

    int total;
    int bad;
    int cyc;

    int short_cnt[2];
    int short_at[2];
    int long_cnt[2];
    int long_at[2];
    int rep_cnt[2];
    int rep_first[2];
    int rep_last[2];
    int held_first[2];
    int held_last[2];
    int multi_cnt;

    key_event #(
        .NUM_KEYS  (2),
        .TICK_DIV  (4),
        .LONG_MS   (5),
        .REPEAT_MS (3)
    ) dut (
        .Sys_CLK   (sys_clk),
        .Sys_RST_N (sys_rst_n),
        .Key_In    (key_in),
        .Key_Short (key_short),
        .Key_Long  (key_long),
        .Key_Rep   (key_rep),
        .Key_Held  (key_held)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] keys);
        key_in = keys;
    endtask

    task automatic clearStats();
        cyc       = 0;
        multi_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            short_cnt[k]  = 0;
            short_at[k]   = -1;
            long_cnt[k]   = 0;
            long_at[k]    = -1;
            rep_cnt[k]    = 0;
            rep_first[k]  = -1;
            rep_last[k]   = -1;
            held_first[k] = -1;
            held_last[k]  = -1;
        end
    endtask

    // Advance n clock edges, sampling outputs 1 time unit after each rising edge.
    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (key_short[k]) begin
                    short_cnt[k]++;
                    short_at[k] = cyc;
                end
                if (key_long[k]) begin
                    long_cnt[k]++;
                    long_at[k] = cyc;
                end
                if (key_rep[k]) begin
                    rep_cnt[k]++;
                    if (rep_first[k] < 0) rep_first[k] = cyc;
                    rep_last[k] = cyc;
                end
                if (key_held[k]) begin
                    if (held_first[k] < 0) held_first[k] = cyc;
                    held_last[k] = cyc;
                end
                if (int'(key_short[k]) + int'(key_long[k]) + int'(key_rep[k]) > 1)
                    multi_cnt++;
            end
        end
    endtask

    task automatic doReset(input logic [1:0] keys);
        applyStimulus(keys);
        sys_rst_n = 1'b0;
        stepCycles(3);
        checkOutput("rst_short", int'(key_short), 0);
        checkOutput("rst_long", int'(key_long), 0);
        checkOutput("rst_rep", int'(key_rep), 0);
        checkOutput("rst_held", int'(key_held), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clearStats();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        sys_rst_n = 1'b0;
        key_in    = 2'b00;
        clearStats();

        // Keys held through reset: seen as a fresh press, released before long.
        doReset(2'b11);
        stepCycles(10);
        applyStimulus(2'b00);
        stepCycles(20);
        checkOutput("s1_short_cnt0", short_cnt[0], 1);
        checkOutput("s1_short_at0", short_at[0], 14);
        checkOutput("s1_short_cnt1", short_cnt[1], 1);
        checkOutput("s1_short_at1", short_at[1], 14);
        checkOutput("s1_long", long_cnt[0] + long_cnt[1], 0);
        checkOutput("s1_held", held_first[0] + held_first[1], -2);

        // Short press on key 0 only.
        doReset(2'b00);
        stepCycles(2);
        applyStimulus(2'b01);
        stepCycles(10);
        applyStimulus(2'b00);
        stepCycles(20);
        checkOutput("s2_short_cnt0", short_cnt[0], 1);
        checkOutput("s2_short_at0", short_at[0], 16);
        checkOutput("s2_long_rep0", long_cnt[0] + rep_cnt[0], 0);
        checkOutput("s2_key1", short_cnt[1] + long_cnt[1] + rep_cnt[1], 0);
        checkOutput("s2_held1", held_first[1], -1);

        // Long press with auto-repeat, then release.
        doReset(2'b00);
        stepCycles(2);
        applyStimulus(2'b01);
        stepCycles(60);
        applyStimulus(2'b00);
        stepCycles(20);
        checkOutput("s3_long_cnt", long_cnt[0], 1);
        checkOutput("s3_long_at", long_at[0], 24);
        checkOutput("s3_held_first", held_first[0], 24);
        checkOutput("s3_held_last", held_last[0], 65);
        checkOutput("s3_rep_cnt", rep_cnt[0], 3);
        checkOutput("s3_rep_first", rep_first[0], 36);
        checkOutput("s3_rep_last", rep_last[0], 60);
        checkOutput("s3_short", short_cnt[0], 0);

        // Release lands on the very tick that would classify the press as long.
        doReset(2'b00);
        stepCycles(2);
        applyStimulus(2'b01);
        stepCycles(18);
        applyStimulus(2'b00);
        stepCycles(20);
        checkOutput("s4_short_cnt", short_cnt[0], 1);
        checkOutput("s4_short_at", short_at[0], 24);
        checkOutput("s4_long", long_cnt[0], 0);
        checkOutput("s4_held", held_first[0], -1);

        // Key 0 short and key 1 long, overlapping.
        doReset(2'b00);
        stepCycles(2);
        applyStimulus(2'b11);
        stepCycles(10);
        applyStimulus(2'b10);
        stepCycles(18);
        applyStimulus(2'b00);
        stepCycles(20);
        checkOutput("s5_short_at0", short_at[0], 16);
        checkOutput("s5_short_cnt0", short_cnt[0], 1);
        checkOutput("s5_long0", long_cnt[0], 0);
        checkOutput("s5_long_at1", long_at[1], 24);
        checkOutput("s5_long_cnt1", long_cnt[1], 1);
        checkOutput("s5_short1", short_cnt[1], 0);
        checkOutput("s5_rep1", rep_cnt[1], 0);
        checkOutput("s5_held_last1", held_last[1], 33);

        // Reset asserted while key 0 is in long hold.
        doReset(2'b00);
        stepCycles(2);
        applyStimulus(2'b01);
        stepCycles(28);
        checkOutput("s6_held_before", int'(key_held[0]), 1);
        checkOutput("s6_held_first", held_first[0], 24);
        sys_rst_n = 1'b0;
        #1;
        checkOutput("s6_held_async", int'(key_held), 0);
        checkOutput("s6_pulses_async", int'({key_short, key_long, key_rep}), 0);
        applyStimulus(2'b00);
        stepCycles(3);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clearStats();
        stepCycles(40);
        checkOutput("s6_events", short_cnt[0] + long_cnt[0] + rep_cnt[0], 0);
        checkOutput("s6_held_after", held_first[0], -1);

        checkOutput("exclusive_pulses", multi_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
